// File: rtl/uart_tx_frame.sv
// UART transmit framer: latches a byte plus external parity on request and
// shifts out start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_frame #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_bit,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (send) begin
          shreg_d    = data_in;
          par_d      = parity_bit;
          par_en_d   = ^parity_type;
          two_stop_d = stop_bits;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = S_ARMED;
        end
      end
      S_ARMED: begin
        if (baud_tick) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? S_PARITY : S_STOP;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency to the line.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: captures the line value after every baud
// tick and compares whole frames against hand-computed bit vectors.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       send;
  logic [7:0] data_in;
  logic       parity_bit;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       tx_out;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;
  int tick_div = 16;
  int tick_ctr = 0;

  uart_tx_frame #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .send        (send),
    .data_in     (data_in),
    .parity_bit  (parity_bit),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .tx_out      (tx_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_ctr >= tick_div - 1) begin
      tick_ctr  = 0;
      baud_tick = 1'b1;
    end else begin
      tick_ctr  = tick_ctr + 1;
      baud_tick = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  // Leaves the bench at the negedge just after the accept edge.
  task automatic start_frame(input logic [7:0] d, input logic p, input logic [1:0] pt,
                             input logic sb, input bit hold);
    @(negedge clk);
    data_in     = d;
    parity_bit  = p;
    parity_type = pt;
    stop_bits   = sb;
    send        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) send = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] exp_vec, input int exp_len,
                           input bit poke, input int abort_at);
    logic [15:0] got = '0;
    logic [15:0] mask;
    int n = 0;
    int cyc = 0;
    int hold_err = 0;
    bit tk;
    bit fin = 1'b0;
    logic cur;
    check_eq({tag, ".armed_busy"}, 32'(busy), 32'd1);
    check_eq({tag, ".armed_tx"}, 32'(tx_out), 32'd1);
    cur = tx_out;
    while (!fin && cyc < 2000) begin
      @(posedge clk);
      tk = baud_tick;
      @(negedge clk);
      cyc++;
      if (tk) begin
        if (n < 16) got[n] = tx_out;
        n++;
      end else if (tx_out !== cur) begin
        hold_err++;
      end
      cur = tx_out;
      if (poke && n == 4) begin
        send        = 1'b1;
        data_in     = 8'h00;
        parity_bit  = 1'b1;
        parity_type = 2'b11;
        stop_bits   = 1'b1;
      end
      if (poke && n == 5) send = 1'b0;
      if (done === 1'b1) fin = 1'b1;
      if (abort_at != 0 && n == abort_at) begin
        check_eq({tag, ".pre_abort_tx"}, 32'(tx_out), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, ".rst_tx"}, 32'(tx_out), 32'd1);
        check_eq({tag, ".rst_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".rst_done"}, 32'(done), 32'd0);
        rst = 1'b0;
        return;
      end
    end
    check_eq({tag, ".done_seen"}, 32'(fin), 32'd1);
    if (fin) begin
      mask = (16'h1 << exp_len) - 16'h1;
      check_eq({tag, ".bits"}, 32'(got & mask), 32'(exp_vec));
      check_eq({tag, ".periods"}, 32'(n - 1), 32'(exp_len));
      check_eq({tag, ".hold"}, 32'(hold_err), 32'd0);
      check_eq({tag, ".done_busy"}, 32'(busy), 32'd0);
      check_eq({tag, ".done_tx"}, 32'(tx_out), 32'd1);
      @(negedge clk);
      check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    send        = 1'b0;
    data_in     = 8'h00;
    parity_bit  = 1'b0;
    parity_type = 2'b00;
    stop_bits   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.tx", 32'(tx_out), 32'd1);
    check_eq("reset.busy", 32'(busy), 32'd0);
    check_eq("reset.done", 32'(done), 32'd0);
    rst = 1'b0;
    watch_idle("reset.idle", 40);

    start_frame(8'hA5, 1'b0, 2'b10, 1'b0, 1'b0);
    run_frame("8E1", 16'h054A, 11, 1'b0, 0);

    start_frame(8'h0F, 1'b1, 2'b01, 1'b1, 1'b0);
    run_frame("8O2", 16'h0E1E, 12, 1'b0, 0);

    start_frame(8'hFF, 1'b0, 2'b11, 1'b0, 1'b0);
    run_frame("8N1", 16'h03FE, 10, 1'b0, 0);

    start_frame(8'hA5, 1'b0, 2'b10, 1'b0, 1'b0);
    run_frame("poke", 16'h054A, 11, 1'b1, 0);
    watch_idle("poke.no_extra", 40);

    start_frame(8'h81, 1'b0, 2'b11, 1'b0, 1'b1);
    run_frame("held1", 16'h0302, 10, 1'b0, 0);
    send = 1'b0;
    run_frame("held2", 16'h0302, 10, 1'b0, 0);
    watch_idle("held.stop", 40);

    tick_div = 1;
    start_frame(8'h3C, 1'b0, 2'b11, 1'b0, 1'b0);
    run_frame("tick1", 16'h0278, 10, 1'b0, 0);
    tick_div = 16;

    start_frame(8'h00, 1'b0, 2'b10, 1'b0, 1'b0);
    run_frame("abort", 16'h0000, 0, 1'b0, 5);
    watch_idle("abort.quiet", 60);
    start_frame(8'h5A, 1'b0, 2'b10, 1'b0, 1'b0);
    run_frame("post", 16'h04B4, 11, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
